obi_write_sub: RTL and testbench

- OBI subordinate endpoint that accepts write transactions on an OBI A channel and forwards each address/data/byte-enable beat to a simple backend write port.
- Returns one R-channel response per accepted request.
- Sits between an OBI manager (e.g. DMA write side) and a memory/model backend.
- One outstanding transaction at a time; fully synchronous.

---
 rtl/obi_write_pkg.sv | 14 +
 rtl/obi_write_sub.sv | 91 +++++++++
 tb/tb_obi_write_sub.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/obi_write_pkg.sv
// rtl/obi_write_pkg.sv - shared state encoding and default widths for the OBI write subordinate
package obi_write_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ID_WIDTH   = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_RESP  = 2'd2
    } obi_state_e;

endpackage

// File: rtl/obi_write_sub.sv
// rtl/obi_write_sub.sv - OBI subordinate forwarding single write beats to a backend port
module obi_write_sub
    import obi_write_pkg::*;
#(
    parameter int AddrWidth = DEF_ADDR_WIDTH,
    parameter int DataWidth = DEF_DATA_WIDTH,
    parameter int IdWidth   = DEF_ID_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_i,
    output logic                   gnt_o,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic                   we_i,
    input  logic [DataWidth/8-1:0] be_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [IdWidth-1:0]     aid_i,
    output logic                   rvalid_o,
    input  logic                   rready_i,
    output logic [DataWidth-1:0]   rdata_o,
    output logic [IdWidth-1:0]     rid_o,
    output logic                   err_o,
    output logic                   wr_valid_o,
    input  logic                   wr_ready_i,
    output logic [AddrWidth-1:0]   wr_addr_o,
    output logic [DataWidth-1:0]   wr_data_o,
    output logic [DataWidth/8-1:0] wr_be_o,
    output logic [31:0]            wr_count_o
);

    obi_state_e             state_q;
    logic [AddrWidth-1:0]   addr_q;
    logic [DataWidth-1:0]   data_q;
    logic [DataWidth/8-1:0] be_q;
    logic [IdWidth-1:0]     aid_q;
    logic                   we_q;
    logic [31:0]            count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
            aid_q   <= '0;
            we_q    <= 1'b0;
            count_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_i) begin
                        addr_q  <= addr_i;
                        data_q  <= wdata_i;
                        be_q    <= be_i;
                        aid_q   <= aid_i;
                        we_q    <= we_i;
                        state_q <= we_i ? ST_WRITE : ST_RESP;
                    end
                end
                ST_WRITE: begin
                    if (wr_ready_i) begin
                        count_q <= count_q + 32'd1;
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rready_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Grant is suppressed during reset so nothing is accepted into a state about to be cleared.
    assign gnt_o      = (state_q == ST_IDLE) && !rst_i;
    assign wr_valid_o = (state_q == ST_WRITE);
    assign rvalid_o   = (state_q == ST_RESP);

    // Only reads are rejected, so the captured write enable is the inverse of the error flag.
    assign err_o      = rvalid_o && !we_q;
    assign rid_o      = aid_q;
    assign rdata_o    = '0;

    assign wr_addr_o  = addr_q;
    assign wr_data_o  = data_q;
    assign wr_be_o    = be_q;
    assign wr_count_o = count_q;

endmodule

// File: tb/tb_obi_write_sub.sv
// tb/tb_obi_write_sub.sv - table and scoreboard bench for obi_write_sub
module tb_obi_write_sub;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic [0:0]  aid_i;
    logic        rvalid_o;
    logic        rready_i;
    logic [31:0] rdata_o;
    logic [0:0]  rid_o;
    logic        err_o;
    logic        wr_valid_o;
    logic        wr_ready_i;
    logic [31:0] wr_addr_o;
    logic [31:0] wr_data_o;
    logic [3:0]  wr_be_o;
    logic [31:0] wr_count_o;

    obi_write_sub dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o),
        .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .aid_i(aid_i),
        .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o), .rid_o(rid_o),
        .err_o(err_o), .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i),
        .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_be_o(wr_be_o),
        .wr_count_o(wr_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        aid;
        logic        we;
        int          w_stall;
        int          r_stall;
        logic        exp_err;
        logic        exp_wr;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_exp_t;

    typedef struct {
        logic rid;
        logic err;
    } r_exp_t;

    wr_exp_t     bq[$];
    r_exp_t      rq[$];
    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;
    logic [31:0] exp_count = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: every handshake must match the oldest expectation queued by the driver.
    always @(negedge clk_i) begin
        if (!rst_i && wr_valid_o && wr_ready_i) begin
            if (bq.size() == 0) begin
                checks++;
                $display("FAIL unexpected_wr: addr %0h with empty scoreboard", wr_addr_o);
            end else begin
                wr_exp_t e;
                e = bq.pop_front();
                chk("sb_wr_addr", wr_addr_o, e.addr);
                chk("sb_wr_data", wr_data_o, e.data);
                chk("sb_wr_be", wr_be_o, e.be);
            end
        end
        if (!rst_i && rvalid_o && rready_i) begin
            if (rq.size() == 0) begin
                checks++;
                $display("FAIL unexpected_resp: rid %0h with empty scoreboard", rid_o);
            end else begin
                r_exp_t r;
                r = rq.pop_front();
                chk("sb_rid", rid_o, r.rid);
                chk("sb_err", err_o, r.err);
                chk("sb_rdata", rdata_o, 0);
            end
        end
    end

    task automatic wait_grant(output int gcyc, output bit ok);
        ok = 1'b0;
        gcyc = 0;
        for (int t = 0; t < 20; t++) begin
            if (gnt_o) begin
                ok = 1'b1;
                gcyc = cyc;
                break;
            end
            step();
        end
        if (!ok) begin
            checks++;
            $display("FAIL grant_timeout: gnt_o stayed %0b, expected 1", gnt_o);
        end
    endtask

    task automatic do_txn(input vec_t v);
        int gc;
        bit ok;
        if (v.exp_wr) bq.push_back('{addr: v.addr, data: v.data, be: v.be});
        rq.push_back('{rid: v.aid, err: v.exp_err});
        req_i      = 1'b1;
        addr_i     = v.addr;
        wdata_i    = v.data;
        be_i       = v.be;
        aid_i      = v.aid;
        we_i       = v.we;
        wr_ready_i = (v.w_stall == 0);
        rready_i   = (v.r_stall == 0);
        wait_grant(gc, ok);
        if (!ok) return;
        step();
        req_i   = 1'b0;
        addr_i  = $urandom;
        wdata_i = $urandom;
        be_i    = 4'($urandom);
        aid_i   = ~v.aid;
        we_i    = ~v.we;
        if (v.exp_wr) begin
            chk("wr_valid_latency", wr_valid_o, 1);
            for (int i = 0; i < v.w_stall; i++) begin
                chk("stall_wr_valid", wr_valid_o, 1);
                chk("stall_wr_addr", wr_addr_o, v.addr);
                chk("stall_wr_data", wr_data_o, v.data);
                chk("stall_wr_be", wr_be_o, v.be);
                chk("stall_gnt", gnt_o, 0);
                step();
            end
            wr_ready_i = 1'b1;
            step();
            exp_count = exp_count + 1;
        end else begin
            chk("read_no_wr_valid", wr_valid_o, 0);
        end
        chk("rvalid_latency", rvalid_o, 1);
        for (int i = 0; i < v.r_stall; i++) begin
            chk("rstall_rvalid", rvalid_o, 1);
            chk("rstall_rid", rid_o, v.aid);
            chk("rstall_err", err_o, v.exp_err);
            chk("rstall_gnt", gnt_o, 0);
            step();
        end
        rready_i = 1'b1;
        step();
        chk("regrant", gnt_o, 1);
        chk("rvalid_drop", rvalid_o, 0);
        chk("wr_count", wr_count_o, exp_count);
    endtask

    vec_t vecs[6];

    initial begin
        int gcs[3];
        int ng;
        bit ok;
        int gc;

        vecs[0] = '{32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, 0, 0, 1'b0, 1'b1};
        vecs[1] = '{32'h0000_2004, 32'h1234_5678, 4'h5, 1'b0, 1'b1, 3, 0, 1'b0, 1'b1};
        vecs[2] = '{32'h0000_3008, 32'hCAFE_F00D, 4'h3, 1'b1, 1'b1, 0, 5, 1'b0, 1'b1};
        vecs[3] = '{32'h0000_2000, 32'h0000_0000, 4'hF, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0};
        vecs[4] = '{32'h0000_4000, 32'hA5A5_A5A5, 4'h0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b1};
        vecs[5] = '{32'h0000_5000, 32'h0000_0000, 4'h8, 1'b1, 1'b0, 0, 3, 1'b1, 1'b0};

        rst_i = 1'b1; req_i = 1'b0; addr_i = '0; we_i = 1'b0; be_i = '0;
        wdata_i = '0; aid_i = '0; wr_ready_i = 1'b1; rready_i = 1'b1;
        step();
        step();
        chk("rst_gnt_low", gnt_o, 0);
        rst_i = 1'b0;
        #1;
        chk("rst_gnt_high", gnt_o, 1);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_wr_valid", wr_valid_o, 0);
        chk("rst_wr_count", wr_count_o, 0);
        chk("rst_wr_addr", wr_addr_o, 0);
        chk("rst_rid", rid_o, 0);
        step();

        for (int k = 0; k < 6; k++) do_txn(vecs[k]);

        // Back-to-back writes with req_i held high: grants must be exactly 3 cycles apart.
        bq.push_back('{addr: 32'h10, data: 32'h1111_0010, be: 4'hF});
        bq.push_back('{addr: 32'h14, data: 32'h2222_0014, be: 4'hC});
        bq.push_back('{addr: 32'h18, data: 32'h3333_0018, be: 4'h1});
        for (int k = 0; k < 3; k++) rq.push_back('{rid: k[0], err: 1'b0});
        ng = 0;
        req_i = 1'b1; we_i = 1'b1; wr_ready_i = 1'b1; rready_i = 1'b1;
        addr_i = 32'h10; wdata_i = 32'h1111_0010; be_i = 4'hF; aid_i = 1'b0;
        for (int t = 0; t < 30 && ng < 3; t++) begin
            if (gnt_o) begin
                gcs[ng] = cyc;
                ng++;
                step();
                addr_i  = 32'h10 + 32'(ng) * 4;
                wdata_i = (ng == 1) ? 32'h2222_0014 : 32'h3333_0018;
                be_i    = (ng == 1) ? 4'hC : 4'h1;
                aid_i   = ng[0];
                if (ng == 3) req_i = 1'b0;
            end else begin
                step();
            end
        end
        chk("b2b_grants", ng, 3);
        if (ng == 3) begin
            chk("b2b_gap1", gcs[1] - gcs[0], 3);
            chk("b2b_gap2", gcs[2] - gcs[1], 3);
        end
        for (int t = 0; t < 4; t++) step();
        exp_count = exp_count + 3;
        chk("b2b_wr_count", wr_count_o, exp_count);

        // Reset while the backend is stalled in WRITE drops the transaction.
        bq.push_back('{addr: 32'h6000, data: 32'h7777_7777, be: 4'hF});
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h6000; wdata_i = 32'h7777_7777;
        be_i = 4'hF; aid_i = 1'b1; wr_ready_i = 1'b0;
        wait_grant(gc, ok);
        step();
        req_i = 1'b0;
        chk("mid_wr_valid", wr_valid_o, 1);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_gnt_low", gnt_o, 0);
        step();
        bq.delete();
        exp_count = 0;
        chk("mid_rst_wr_valid", wr_valid_o, 0);
        chk("mid_rst_rvalid", rvalid_o, 0);
        chk("mid_rst_count", wr_count_o, 0);
        rst_i = 1'b0;
        wr_ready_i = 1'b1;
        #1;
        chk("mid_rel_gnt", gnt_o, 1);
        for (int t = 0; t < 4; t++) begin
            step();
            chk("mid_no_rvalid", rvalid_o, 0);
        end

        chk("sb_wr_drained", bq.size(), 0);
        chk("sb_r_drained", rq.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
